// File: rtl/fpu_issue_stage_pkg.sv
// Shared FPU definitions: issue-stage FSM states and the FPU opcode encodings.
package fpu_issue_stage_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_EXEC    = 2'd1,
      ST_WAIT_MC = 2'd2,
      ST_WB      = 2'd3
   } fpu_issue_state_e;

   localparam logic [4:0] OP_FSGNJ  = 5'b10001;
   localparam logic [4:0] OP_FSGNJN = 5'b10010;
   localparam logic [4:0] OP_FSGNJX = 5'b10011;
   localparam logic [4:0] OP_FDIV   = 5'b10100;
   localparam logic [4:0] OP_FSQRT  = 5'b10101;

endpackage

// File: rtl/fpu_issue_stage.sv
// Single-issue FPU stage: holds one instruction, dispatches it to the single- or
// multi-cycle units and presents the result on a valid/ready writeback port.
//
// state   | meaning
// IDLE    | empty, o_ready=1, accepts a decoded instruction
// EXEC    | operands on the FPU bus; single-cycle result captured or MC unit started
// WAIT_MC | multi-cycle unit busy, waiting for i_mc_done
// WB      | o_wb_valid held until i_wb_ready
module fpu_issue_stage
   import fpu_issue_stage_pkg::*;
#(
   parameter logic [4:0] MC_OP0 = OP_FDIV,
   parameter logic [4:0] MC_OP1 = OP_FSQRT
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_valid,
   output logic        o_ready,
   input  logic [31:0] i_operand_a,
   input  logic [31:0] i_operand_b,
   input  logic [4:0]  i_alu_op,
   input  logic [4:0]  i_rd,
   input  logic        i_flush,
   output logic [31:0] o_operand_a,
   output logic [31:0] o_operand_b,
   output logic [4:0]  o_alu_op,
   input  logic [31:0] i_sc_result,
   output logic        o_mc_start,
   input  logic        i_mc_done,
   input  logic [31:0] i_mc_result,
   output logic        o_wb_valid,
   input  logic        i_wb_ready,
   output logic [4:0]  o_wb_rd,
   output logic [31:0] o_wb_data
);

   fpu_issue_state_e state_q;
   logic [4:0]       rd_q;
   logic             in_is_mc;
   logic             held_is_mc;

   assign in_is_mc   = (i_alu_op == MC_OP0) || (i_alu_op == MC_OP1);
   assign held_is_mc = (o_alu_op == MC_OP0) || (o_alu_op == MC_OP1);
   assign o_ready    = (state_q == ST_IDLE);
   assign o_wb_rd    = rd_q;

   // o_mc_start is registered, so it is set on the accepting edge to be high
   // exactly during the EXEC cycle of a multi-cycle op.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= ST_IDLE;
         o_operand_a <= '0;
         o_operand_b <= '0;
         o_alu_op    <= '0;
         rd_q        <= '0;
         o_wb_data   <= '0;
         o_mc_start  <= 1'b0;
         o_wb_valid  <= 1'b0;
      end else if (i_flush) begin
         state_q    <= ST_IDLE;
         o_mc_start <= 1'b0;
         o_wb_valid <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (i_valid) begin
                  o_operand_a <= i_operand_a;
                  o_operand_b <= i_operand_b;
                  o_alu_op    <= i_alu_op;
                  rd_q        <= i_rd;
                  o_mc_start  <= in_is_mc;
                  state_q     <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               o_mc_start <= 1'b0;
               if (held_is_mc) begin
                  state_q <= ST_WAIT_MC;
               end else begin
                  o_wb_data  <= i_sc_result;
                  o_wb_valid <= 1'b1;
                  state_q    <= ST_WB;
               end
            end
            ST_WAIT_MC: begin
               if (i_mc_done) begin
                  o_wb_data  <= i_mc_result;
                  o_wb_valid <= 1'b1;
                  state_q    <= ST_WB;
               end
            end
            ST_WB: begin
               if (i_wb_ready) begin
                  o_wb_valid <= 1'b0;
                  state_q    <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_issue_stage.sv
// Directed bench for fpu_issue_stage: expected writebacks are queued by the
// stimulus and checked by a separate monitor on every writeback handshake.
module tb_fpu_issue_stage;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        i_valid;
   logic        o_ready;
   logic [31:0] i_operand_a;
   logic [31:0] i_operand_b;
   logic [4:0]  i_alu_op;
   logic [4:0]  i_rd;
   logic        i_flush;
   logic [31:0] o_operand_a;
   logic [31:0] o_operand_b;
   logic [4:0]  o_alu_op;
   logic [31:0] i_sc_result;
   logic        o_mc_start;
   logic        i_mc_done;
   logic [31:0] i_mc_result;
   logic        o_wb_valid;
   logic        i_wb_ready;
   logic [4:0]  o_wb_rd;
   logic [31:0] o_wb_data;

   int errors = 0;
   int checks = 0;
   logic [36:0] exp_q[$];

   fpu_issue_stage dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
      .i_operand_a(i_operand_a), .i_operand_b(i_operand_b), .i_alu_op(i_alu_op),
      .i_rd(i_rd), .i_flush(i_flush), .o_operand_a(o_operand_a),
      .o_operand_b(o_operand_b), .o_alu_op(o_alu_op), .i_sc_result(i_sc_result),
      .o_mc_start(o_mc_start), .i_mc_done(i_mc_done), .i_mc_result(i_mc_result),
      .o_wb_valid(o_wb_valid), .i_wb_ready(i_wb_ready), .o_wb_rd(o_wb_rd),
      .o_wb_data(o_wb_data)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic issue(input logic [4:0] op, input logic [4:0] rd,
                        input logic [31:0] a, input logic [31:0] b);
      i_valid     = 1'b1;
      i_alu_op    = op;
      i_rd        = rd;
      i_operand_a = a;
      i_operand_b = b;
      tick();
      i_valid = 1'b0;
   endtask

   // Scoreboard monitor: every handshake must match the oldest queued writeback.
   always @(negedge i_clk) begin
      if (i_rst_n && o_wb_valid && i_wb_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_wb", {27'd0, o_wb_rd}, 32'hFFFF_FFFF);
         end else begin
            logic [36:0] e;
            e = exp_q.pop_front();
            chk("wb_rd", {27'd0, o_wb_rd}, {27'd0, e[36:32]});
            chk("wb_data", o_wb_data, e[31:0]);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] held_a;
      i_rst_n = 1'b0; i_valid = 1'b0; i_flush = 1'b0; i_mc_done = 1'b0;
      i_operand_a = '0; i_operand_b = '0; i_alu_op = '0; i_rd = '0;
      i_sc_result = '0; i_mc_result = '0; i_wb_ready = 1'b1;
      #2;
      chk("rst_ready", {31'd0, o_ready}, 32'd1);
      chk("rst_wb_valid", {31'd0, o_wb_valid}, 32'd0);
      chk("rst_operand_a", o_operand_a, 32'd0);
      tick();
      i_rst_n = 1'b1;
      tick();

      // FSGNJ: single-cycle, writeback two cycles after accept
      i_sc_result = 32'hBF80_0000;
      exp_q.push_back({5'd3, 32'hBF80_0000});
      issue(5'b10001, 5'd3, 32'h3F80_0000, 32'hC000_0000);
      chk("sc_exec_ready", {31'd0, o_ready}, 32'd0);
      chk("sc_exec_wb_valid", {31'd0, o_wb_valid}, 32'd0);
      chk("sc_exec_mc_start", {31'd0, o_mc_start}, 32'd0);
      chk("sc_operand_a", o_operand_a, 32'h3F80_0000);
      chk("sc_operand_b", o_operand_b, 32'hC000_0000);
      chk("sc_alu_op", {27'd0, o_alu_op}, 32'h11);
      tick();
      chk("sc_wb_valid_c2", {31'd0, o_wb_valid}, 32'd1);
      chk("sc_wb_data_c2", o_wb_data, 32'hBF80_0000);
      tick();
      chk("sc_idle_ready", {31'd0, o_ready}, 32'd1);
      chk("sc_idle_wb_valid", {31'd0, o_wb_valid}, 32'd0);

      // FDIV: done pulsed 7 cycles after the start pulse
      i_sc_result = 32'hDEAD_BEEF;
      exp_q.push_back({5'd7, 32'h4040_0000});
      issue(5'b10100, 5'd7, 32'h40C0_0000, 32'h4000_0000);
      chk("mc_start_high", {31'd0, o_mc_start}, 32'd1);
      for (int i = 1; i < 7; i++) begin
         tick();
         chk("mc_start_low", {31'd0, o_mc_start}, 32'd0);
         chk("mc_wait_wb_valid", {31'd0, o_wb_valid}, 32'd0);
         chk("mc_wait_operand_a", o_operand_a, 32'h40C0_0000);
      end
      tick();
      i_mc_done = 1'b1;
      i_mc_result = 32'h4040_0000;
      tick();
      i_mc_done = 1'b0;
      i_mc_result = 32'h0BAD_0BAD;
      chk("mc_wb_valid", {31'd0, o_wb_valid}, 32'd1);
      chk("mc_wb_data", o_wb_data, 32'h4040_0000);
      tick();
      chk("mc_idle_ready", {31'd0, o_ready}, 32'd1);

      // Writeback backpressure for 5 cycles
      i_wb_ready = 1'b0;
      i_sc_result = 32'h1234_5678;
      exp_q.push_back({5'd12, 32'h1234_5678});
      issue(5'b10010, 5'd12, 32'h0000_0001, 32'h8000_0000);
      tick();
      i_sc_result = 32'h5555_AAAA;
      for (int i = 0; i < 5; i++) begin
         chk("bp_wb_valid", {31'd0, o_wb_valid}, 32'd1);
         chk("bp_wb_rd", {27'd0, o_wb_rd}, 32'd12);
         chk("bp_wb_data", o_wb_data, 32'h1234_5678);
         chk("bp_ready", {31'd0, o_ready}, 32'd0);
         tick();
      end
      i_wb_ready = 1'b1;
      tick();
      chk("bp_idle_ready", {31'd0, o_ready}, 32'd1);
      chk("bp_idle_wb_valid", {31'd0, o_wb_valid}, 32'd0);

      // Flush during WAIT_MC, then a stale done
      issue(5'b10101, 5'd9, 32'h40E0_0000, 32'h0);
      tick();
      tick();
      i_flush = 1'b1;
      tick();
      i_flush = 1'b0;
      chk("fl_ready", {31'd0, o_ready}, 32'd1);
      chk("fl_wb_valid", {31'd0, o_wb_valid}, 32'd0);
      chk("fl_mc_start", {31'd0, o_mc_start}, 32'd0);
      tick();
      i_mc_done = 1'b1;
      i_mc_result = 32'h7777_7777;
      tick();
      i_mc_done = 1'b0;
      chk("stale_wb_valid", {31'd0, o_wb_valid}, 32'd0);
      chk("stale_ready", {31'd0, o_ready}, 32'd1);
      tick();
      chk("stale_wb_valid2", {31'd0, o_wb_valid}, 32'd0);

      // Flush and valid together in IDLE: not accepted
      held_a = 32'h40E0_0000;
      i_flush = 1'b1;
      issue(5'b10011, 5'd1, 32'hAAAA_AAAA, 32'hBBBB_BBBB);
      i_flush = 1'b0;
      chk("fv_ready", {31'd0, o_ready}, 32'd1);
      chk("fv_operand_a", o_operand_a, held_a);
      chk("fv_alu_op", {27'd0, o_alu_op}, 32'h15);
      tick();
      chk("fv_ready2", {31'd0, o_ready}, 32'd1);

      // Async reset mid-WB
      i_wb_ready = 1'b0;
      i_sc_result = 32'h8000_0001;
      issue(5'b10011, 5'd5, 32'hC0A0_0000, 32'h3F00_0000);
      tick();
      chk("rw_wb_valid", {31'd0, o_wb_valid}, 32'd1);
      #2;
      i_rst_n = 1'b0;
      #1;
      chk("ar_wb_valid", {31'd0, o_wb_valid}, 32'd0);
      chk("ar_wb_data", o_wb_data, 32'd0);
      chk("ar_wb_rd", {27'd0, o_wb_rd}, 32'd0);
      chk("ar_operand_a", o_operand_a, 32'd0);
      chk("ar_operand_b", o_operand_b, 32'd0);
      chk("ar_alu_op", {27'd0, o_alu_op}, 32'd0);
      chk("ar_mc_start", {31'd0, o_mc_start}, 32'd0);
      tick();
      i_rst_n = 1'b1;
      i_wb_ready = 1'b1;
      tick();
      chk("ar_release_ready", {31'd0, o_ready}, 32'd1);
      chk("ar_release_wb_valid", {31'd0, o_wb_valid}, 32'd0);

      tick();
      chk("queue_drained", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fpu_issue_stage.md
FPU_ISSUE_STAGE -- requirements
Module: fpu_issue_stage

Interface
REQ-001 SHALL declare parameter MC_OP0, default 5'b10100, the FDIV opcode and a multi-cycle operation.
REQ-002 SHALL declare parameter MC_OP1, default 5'b10101, the FSQRT opcode and a multi-cycle operation.
REQ-003 SHALL use one clock and an asynchronous, active-low reset, with these ports:
- i_clk  input  1  sole clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  decoded FP instruction available.
- o_ready  output  1  stage can accept an instruction.
- i_operand_a  input  32  rs1 value.
- i_operand_b  input  32  rs2 value.
- i_alu_op  input  5  FPU opcode.
- i_rd  input  5  destination FP register.
- i_flush  input  1  squash the in-flight instruction.
- o_operand_a  output  32  registered operand A to the FPU units.
- o_operand_b  output  32  registered operand B to the FPU units.
- o_alu_op  output  5  registered opcode to the FPU units.
- i_sc_result  input  32  combinational result from the single-cycle units (sign-inject and the other single-cycle units).
- o_mc_start  output  1  one-cycle start pulse to the multi-cycle unit.
- i_mc_done  input  1  multi-cycle result valid.
- i_mc_result  input  32  multi-cycle result.
- o_wb_valid  output  1  writeback request.
- i_wb_ready  input  1  writeback accepted.
- o_wb_rd  output  5  writeback destination register.
- o_wb_data  output  32  writeback data.

Function
REQ-004 SHALL implement the FSM IDLE, EXEC, WAIT_MC, WB.
REQ-005 SHALL drive o_ready=1 only in IDLE; at most one instruction is in flight.
REQ-006 SHALL, in IDLE, on i_valid&o_ready:
- latch the operands, opcode and rd into o_operand_a, o_operand_b, o_alu_op and a rd register;
- go to EXEC.
REQ-007 SHALL, in EXEC with o_alu_op not equal to MC_OP0 or MC_OP1:
- capture i_sc_result into o_wb_data;
- go to WB.
- Accept-to-o_wb_valid latency is exactly 2 cycles.
REQ-008 SHALL, in EXEC with a multi-cycle opcode, assert o_mc_start for exactly that one cycle and go to WAIT_MC.
REQ-009 SHALL, in WAIT_MC, hold all registered outputs stable until i_mc_done=1, then capture i_mc_result into o_wb_data and go to WB.
REQ-010 SHALL ignore i_mc_done in every state except WAIT_MC.
REQ-011 SHALL, in WB, assert o_wb_valid with o_wb_rd and o_wb_data stable until i_wb_ready=1, then go to IDLE.
- o_ready rises the cycle after the handshake.
REQ-012 SHALL, when i_flush=1, go to IDLE next cycle from any state and deassert o_wb_valid and o_mc_start; flush has priority over every other transition.
REQ-013 SHALL not accept a new instruction in a cycle where i_flush=1 and i_valid=1 in IDLE (flush wins).
REQ-014 SHALL not modify o_operand_a, o_operand_b or o_alu_op outside an IDLE acceptance.

Reset
REQ-015 SHALL, on i_rst_n=0, immediately and asynchronously:
- force state to IDLE;
- clear o_operand_a, o_operand_b, o_wb_data and o_alu_op to 0;
- clear o_wb_rd to 0;
- clear o_mc_start and o_wb_valid to 0;
- o_ready is 1 once i_rst_n is released.
REQ-016 SHALL, on reset asserted mid-WAIT_MC, drop the in-flight instruction; a later stale i_mc_done is ignored per REQ-010.

Structure
REQ-017 SHALL take the FSM state enum and the FPU opcode constants (FSGNJ 10001, FSGNJN 10010, FSGNJX 10011, FDIV 10100, FSQRT 10101) from the shared FPU package.
REQ-018 SHALL be one module with no sub-modules.
REQ-019 SHALL register all outputs except o_ready, which is decoded from state.

Verification
REQ-020 SHALL cover FSGNJ:
- Stimulus: A=0x3F800000, B=0xC0000000, op=10001, rd=3, accepted in cycle 0.
- Required: o_wb_valid=1 in cycle 2, o_wb_data=i_sc_result=0xBF800000, o_wb_rd=3.
REQ-021 SHALL cover FDIV:
- Stimulus: op=10100; i_mc_done pulsed 7 cycles after o_mc_start with i_mc_result=0x40400000.
- Required: o_mc_start high exactly 1 cycle; o_wb_valid the cycle after i_mc_done; data 0x40400000.
REQ-022 SHALL cover writeback backpressure:
- Stimulus: hold i_wb_ready=0 for 5 cycles.
- Required: o_wb_valid, o_wb_rd and o_wb_data stable throughout; o_ready=0; IDLE the cycle after i_wb_ready=1.
REQ-023 SHALL cover flush during WAIT_MC, then a stale i_mc_done:
- Stimulus: i_flush in WAIT_MC; i_mc_done pulsed later.
- Required: IDLE next cycle, no o_wb_valid; the stale i_mc_done produces no writeback.
REQ-024 SHALL cover simultaneous i_flush and i_valid in IDLE: the instruction is not accepted and o_operand_a is unchanged.
REQ-025 SHALL cover asynchronous reset asserted mid-WB: all outputs clear without a clock edge; o_ready=1 after release.
